// File: rtl/rf_writeback_ctrl_if.sv
// Writeback-side bundle: pipeline and long-latency sources in, register-file write port and hazard status out.
// master drives the sources and queries; slave is the writeback controller.
interface rf_writeback_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int QDEPTH = 4,
  parameter int CW     = $clog2(QDEPTH) + 1
);
  logic             wb_we;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             lu_valid;
  logic [4:0]       lu_addr;
  logic [WIDTH-1:0] lu_data;
  logic             lu_ready;
  logic             WE;
  logic [4:0]       A3;
  logic [WIDTH-1:0] WD3;
  logic [4:0]       q_addr1;
  logic [4:0]       q_addr2;
  logic             q_busy1;
  logic             q_busy2;
  logic [CW-1:0]    q_count;
  logic             drain_req;

  modport master (
    output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, q_addr1, q_addr2,
    input  lu_ready, WE, A3, WD3, q_busy1, q_busy2, q_count, drain_req
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, q_addr1, q_addr2,
    output lu_ready, WE, A3, WD3, q_busy1, q_busy2, q_count, drain_req
  );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Merges pipeline writeback (priority, 1 cycle to WE) with a queued long-latency source (>=2 cycles to WE).
// Backpressure: lu_ready drops while the FIFO is full; drain_req asks the pipeline for a bubble.
module rf_writeback_ctrl #(
  parameter int WIDTH  = 32,
  parameter int QDEPTH = 4,
  parameter int CW     = $clog2(QDEPTH) + 1
) (
  input  logic                CLK,
  input  logic                RST,
  rf_writeback_ctrl_if.slave  bus
);
  localparam int PW = $clog2(QDEPTH);
  typedef logic [PW-1:0] ptr_t;

  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [4:0]       ent_addr_q [QDEPTH];
  logic [4:0]       ent_addr_d [QDEPTH];
  logic [WIDTH-1:0] ent_data_q [QDEPTH];
  logic [WIDTH-1:0] ent_data_d [QDEPTH];
  logic [QDEPTH-1:0] ent_vld_q, ent_vld_d;
  logic             we_q, we_d;
  logic [4:0]       a3_q, a3_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;

  logic pw, push, pop, lu_ready;
  logic hit1, hit2;

  assign lu_ready = (count_q < CW'(QDEPTH));
  assign pw       = bus.wb_we && (bus.wb_addr != 5'd0);
  assign push     = bus.lu_valid && lu_ready && (bus.lu_addr != 5'd0);
  // Arbitration uses only current state, so a word pushed this cycle cannot pop until next cycle.
  assign pop      = !pw && (count_q != '0);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    ent_vld_d  = ent_vld_q;
    we_d       = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;

    if (pw) begin
      we_d  = 1'b1;
      a3_d  = bus.wb_addr;
      wd3_d = bus.wb_data;
    end else if (pop) begin
      we_d                = 1'b1;
      a3_d                = ent_addr_q[rd_ptr_q];
      wd3_d               = ent_data_q[rd_ptr_q];
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + 1'b1;
    end

    if (push) begin
      ent_addr_d[wr_ptr_q] = bus.lu_addr;
      ent_data_d[wr_ptr_q] = bus.lu_data;
      ent_vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ent_vld_q <= '0;
      we_q      <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ent_vld_q  <= ent_vld_d;
      we_q       <= we_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
    end
  end

  // A write is still pending while queued or while sitting on the output register before the negedge commit.
  always_comb begin
    hit1 = we_q && (a3_q == bus.q_addr1);
    hit2 = we_q && (a3_q == bus.q_addr2);
    for (int i = 0; i < QDEPTH; i++) begin
      if (ent_vld_q[i] && (ent_addr_q[i] == bus.q_addr1)) hit1 = 1'b1;
      if (ent_vld_q[i] && (ent_addr_q[i] == bus.q_addr2)) hit2 = 1'b1;
    end
  end

  assign bus.q_busy1   = (bus.q_addr1 != 5'd0) && hit1;
  assign bus.q_busy2   = (bus.q_addr2 != 5'd0) && hit2;
  assign bus.lu_ready  = lu_ready;
  assign bus.q_count   = count_q;
  assign bus.drain_req = (count_q == CW'(QDEPTH));
  assign bus.WE        = we_q;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;
endmodule
